wbu_arb: RTL and testbench

- Writeback stage directly upstream of the integer register file write port.
- Accepts completed results from two producers over valid/ready handshakes: the execute unit (ALU/CSR results, branches, stores) and the load/store unit (load returns).
- Arbitrates between them, aligns and sign/zero-extends load data, and drives one registered write per cycle into the register file.
- Counts retired instructions for the simulation harness.

---
 rtl/wbu_arb_if.sv | 43 ++++
 rtl/wbu_arb.sv | 104 ++++++++++
 tb/tb_wbu_arb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/wbu_arb_if.sv
// rtl/wbu_arb_if.sv - producer handshakes and register-file write bundle for wbu_arb
interface wbu_arb_if #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5
);
    // EXU result channel
    logic                 i_exu_valid;
    logic                 o_exu_ready;
    logic [REG_ADDRW-1:0] i_exu_rd;
    logic                 i_exu_wen;
    logic [CPU_WIDTH-1:0] i_exu_data;

    // LSU load-return channel
    logic                 i_lsu_valid;
    logic                 o_lsu_ready;
    logic [REG_ADDRW-1:0] i_lsu_rd;
    logic [2:0]           i_lsu_funct3;
    logic [2:0]           i_lsu_off;
    logic [CPU_WIDTH-1:0] i_lsu_rdata;

    // Register-file write port and retire status
    logic                 o_rf_wen;
    logic [REG_ADDRW-1:0] o_rf_waddr;
    logic [CPU_WIDTH-1:0] o_rf_wdata;
    logic                 o_commit;
    logic [63:0]          o_instret;

    // Producer / harness side
    modport master (
        output i_exu_valid, i_exu_rd, i_exu_wen, i_exu_data,
        output i_lsu_valid, i_lsu_rd, i_lsu_funct3, i_lsu_off, i_lsu_rdata,
        input  o_exu_ready, o_lsu_ready,
        input  o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit, o_instret
    );

    // Writeback stage side
    modport slave (
        input  i_exu_valid, i_exu_rd, i_exu_wen, i_exu_data,
        input  i_lsu_valid, i_lsu_rd, i_lsu_funct3, i_lsu_off, i_lsu_rdata,
        output o_exu_ready, o_lsu_ready,
        output o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit, o_instret
    );
endinterface

// File: rtl/wbu_arb.sv
// rtl/wbu_arb.sv - writeback arbiter between EXU and LSU with load formatting and retire count
module wbu_arb #(
    parameter int CPU_WIDTH  = 64,
    parameter int REG_ADDRW  = 5,
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    wbu_arb_if.slave     bus
);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rf_wen_q, rf_wen_d;
    logic [REG_ADDRW-1:0] rf_waddr_q, rf_waddr_d;
    logic [CPU_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                 commit_q, commit_d;
    logic [63:0]          instret_q, instret_d;

    logic                 exu_win;
    logic                 lsu_win;
    logic                 starved;
    logic [CPU_WIDTH-1:0] shifted;
    logic [CPU_WIDTH-1:0] load_data;

    // Grant: a lone valid wins; on contention the LSU wins unless the EXU has starved
    always_comb begin
        starved = (cnt_q == CNT_W'(STARVE_MAX));
        exu_win = bus.i_exu_valid && (!bus.i_lsu_valid || starved);
        lsu_win = bus.i_lsu_valid && !exu_win;
    end

    assign bus.o_exu_ready = exu_win;
    assign bus.o_lsu_ready = lsu_win;

    // Align the doubleword to the access offset, then sign/zero-extend by load type
    always_comb begin
        shifted   = bus.i_lsu_rdata >> {bus.i_lsu_off, 3'b000};
        load_data = shifted;
        case (bus.i_lsu_funct3)
            3'b000:  load_data = {{(CPU_WIDTH-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_data = {{(CPU_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = {{(CPU_WIDTH-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_data = {{(CPU_WIDTH-8){1'b0}},         shifted[7:0]};
            3'b101:  load_data = {{(CPU_WIDTH-16){1'b0}},        shifted[15:0]};
            3'b110:  load_data = {{(CPU_WIDTH-32){1'b0}},        shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // Next-state for the starvation counter, write port and retire counter
    always_comb begin
        cnt_d      = cnt_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        commit_d   = exu_win || lsu_win;
        instret_d  = instret_q;

        if (!bus.i_exu_valid || exu_win) begin
            cnt_d = '0;
        end else if (!starved) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (exu_win) begin
            rf_wen_d   = bus.i_exu_wen && (bus.i_exu_rd != '0);
            rf_waddr_d = bus.i_exu_rd;
            rf_wdata_d = bus.i_exu_data;
        end else if (lsu_win) begin
            rf_wen_d   = (bus.i_lsu_rd != '0);
            rf_waddr_d = bus.i_lsu_rd;
            rf_wdata_d = load_data;
        end

        if (commit_d) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // State registers; reset drops any handshake in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q      <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            commit_q   <= 1'b0;
            instret_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            commit_q   <= commit_d;
            instret_q  <= instret_d;
        end
    end

    assign bus.o_rf_wen   = rf_wen_q;
    assign bus.o_rf_waddr = rf_waddr_q;
    assign bus.o_rf_wdata = rf_wdata_q;
    assign bus.o_commit   = commit_q;
    assign bus.o_instret  = instret_q;
endmodule

// File: tb/tb_wbu_arb.sv
// tb/tb_wbu_arb.sv - directed vector bench for wbu_arb
module tb_wbu_arb;
    logic i_clk;
    logic i_rst;

    wbu_arb_if #(.CPU_WIDTH(64), .REG_ADDRW(5)) bus ();

    wbu_arb #(
        .CPU_WIDTH (64),
        .REG_ADDRW (5),
        .STARVE_MAX(3),
        .CNT_W     (2)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ev;
        logic [4:0]  erd;
        logic        ewen;
        logic [63:0] edata;
        logic        lv;
        logic [4:0]  lrd;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] rdata;
        logic        x_wen;
        logic [4:0]  x_waddr;
        logic [63:0] x_wdata;
    } vec_t;

    vec_t        vecs[14];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] exp_instret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_in();
        bus.i_exu_valid  = 1'b0;
        bus.i_exu_rd     = '0;
        bus.i_exu_wen    = 1'b0;
        bus.i_exu_data   = '0;
        bus.i_lsu_valid  = 1'b0;
        bus.i_lsu_rd     = '0;
        bus.i_lsu_funct3 = '0;
        bus.i_lsu_off    = '0;
        bus.i_lsu_rdata  = '0;
    endtask

    task automatic set_exu(input logic [4:0] rd, input logic wen, input logic [63:0] d);
        bus.i_exu_valid = 1'b1;
        bus.i_exu_rd    = rd;
        bus.i_exu_wen   = wen;
        bus.i_exu_data  = d;
    endtask

    task automatic set_lsu(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off,
                           input logic [63:0] d);
        bus.i_lsu_valid  = 1'b1;
        bus.i_lsu_rd     = rd;
        bus.i_lsu_funct3 = f3;
        bus.i_lsu_off    = off;
        bus.i_lsu_rdata  = d;
    endtask

    initial begin
        logic [7:0] pat;
        int ei;
        int li;
        logic [63:0] exp_d;
        logic [4:0]  exp_a;

        //           ev erd ewen edata        lv lrd f3     off    rdata                  wen waddr wdata
        vecs[0]  = '{1, 5,  1, 64'h1234,      0, 0,  3'b000, 3'd0, 64'h0,                 1, 5,  64'h1234};
        vecs[1]  = '{0, 0,  0, 64'h0,         1, 3,  3'b000, 3'd7, 64'h80FF_0000_0000_0000, 1, 3, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[2]  = '{0, 0,  0, 64'h0,         1, 3,  3'b100, 3'd7, 64'h80FF_0000_0000_0000, 1, 3, 64'h80};
        vecs[3]  = '{0, 0,  0, 64'h0,         1, 4,  3'b010, 3'd4, 64'h80FF_0000_0000_0000, 1, 4, 64'hFFFF_FFFF_80FF_0000};
        vecs[4]  = '{0, 0,  0, 64'h0,         1, 4,  3'b110, 3'd4, 64'h80FF_0000_0000_0000, 1, 4, 64'h80FF_0000};
        vecs[5]  = '{0, 0,  0, 64'h0,         0, 0,  3'b000, 3'd0, 64'h0,                 0, 4,  64'h80FF_0000};
        vecs[6]  = '{1, 0,  1, 64'hDEAD,      0, 0,  3'b000, 3'd0, 64'h0,                 0, 0,  64'hDEAD};
        vecs[7]  = '{1, 7,  0, 64'h55,        0, 0,  3'b000, 3'd0, 64'h0,                 0, 7,  64'h55};
        vecs[8]  = '{0, 0,  0, 64'h0,         1, 31, 3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 1, 31, 64'h0123_4567_89AB_CDEF};
        vecs[9]  = '{0, 0,  0, 64'h0,         1, 30, 3'b111, 3'd0, 64'hFEDC_BA98_7654_3210, 1, 30, 64'hFEDC_BA98_7654_3210};
        vecs[10] = '{0, 0,  0, 64'h0,         1, 2,  3'b001, 3'd2, 64'h0000_0000_8001_0000, 1, 2,  64'hFFFF_FFFF_FFFF_8001};
        vecs[11] = '{0, 0,  0, 64'h0,         1, 2,  3'b101, 3'd2, 64'h0000_0000_8001_0000, 1, 2,  64'h8001};
        vecs[12] = '{0, 0,  0, 64'h0,         1, 0,  3'b011, 3'd0, 64'h77,                0, 0,  64'h77};
        vecs[13] = '{0, 0,  0, 64'h0,         0, 0,  3'b000, 3'd0, 64'h0,                 0, 0,  64'h77};

        idle_in();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_wen",     bus.o_rf_wen,    0);
        chk("reset_waddr",   bus.o_rf_waddr,  0);
        chk("reset_wdata",   bus.o_rf_wdata,  0);
        chk("reset_commit",  bus.o_commit,    0);
        chk("reset_instret", bus.o_instret,   0);
        exp_instret = 0;

        @(negedge i_clk);
        i_rst = 1'b0;

        // Table-driven single-source vectors
        for (int i = 0; i < 14; i++) begin
            @(negedge i_clk);
            idle_in();
            if (vecs[i].ev) set_exu(vecs[i].erd, vecs[i].ewen, vecs[i].edata);
            if (vecs[i].lv) set_lsu(vecs[i].lrd, vecs[i].f3, vecs[i].off, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d_exu_ready", i), bus.o_exu_ready, vecs[i].ev);
            chk($sformatf("v%0d_lsu_ready", i), bus.o_lsu_ready, vecs[i].lv);
            @(posedge i_clk);
            #1;
            if (vecs[i].ev || vecs[i].lv) exp_instret = exp_instret + 1;
            chk($sformatf("v%0d_wen", i),     bus.o_rf_wen,   vecs[i].x_wen);
            chk($sformatf("v%0d_waddr", i),   bus.o_rf_waddr, vecs[i].x_waddr);
            chk($sformatf("v%0d_wdata", i),   bus.o_rf_wdata, vecs[i].x_wdata);
            chk($sformatf("v%0d_commit", i),  bus.o_commit,   vecs[i].ev || vecs[i].lv);
            chk($sformatf("v%0d_instret", i), bus.o_instret,  exp_instret);
        end

        // Both producers continuously valid: expect L,L,L,E,L,L,L,E
        pat = 8'b1000_1000;
        ei = 0;
        li = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            idle_in();
            set_exu(5'(10 + ei), 1'b1, 64'h1000 + 64'(ei));
            set_lsu(5'(20 + li), 3'b011, 3'd0, 64'h2000 + 64'(li));
            #1;
            chk($sformatf("starve%0d_exu_ready", c), bus.o_exu_ready, pat[c]);
            chk($sformatf("starve%0d_lsu_ready", c), bus.o_lsu_ready, !pat[c]);
            if (pat[c]) begin
                exp_a = 5'(10 + ei);
                exp_d = 64'h1000 + 64'(ei);
                ei++;
            end else begin
                exp_a = 5'(20 + li);
                exp_d = 64'h2000 + 64'(li);
                li++;
            end
            @(posedge i_clk);
            #1;
            exp_instret = exp_instret + 1;
            chk($sformatf("starve%0d_waddr", c),   bus.o_rf_waddr, exp_a);
            chk($sformatf("starve%0d_wdata", c),   bus.o_rf_wdata, exp_d);
            chk($sformatf("starve%0d_commit", c),  bus.o_commit,   1);
            chk($sformatf("starve%0d_instret", c), bus.o_instret,  exp_instret);
        end

        // Reset coinciding with an LSU handshake drops it; the held transfer completes afterwards
        @(negedge i_clk);
        idle_in();
        set_lsu(5'd9, 3'b011, 3'd0, 64'hABCD);
        i_rst = 1'b1;
        #1;
        chk("rst_xfer_lsu_ready", bus.o_lsu_ready, 1);
        @(posedge i_clk);
        #1;
        exp_instret = 0;
        chk("rst_xfer_wen",     bus.o_rf_wen,   0);
        chk("rst_xfer_waddr",   bus.o_rf_waddr, 0);
        chk("rst_xfer_wdata",   bus.o_rf_wdata, 0);
        chk("rst_xfer_commit",  bus.o_commit,   0);
        chk("rst_xfer_instret", bus.o_instret,  0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        exp_instret = 1;
        chk("post_rst_wen",     bus.o_rf_wen,   1);
        chk("post_rst_waddr",   bus.o_rf_waddr, 9);
        chk("post_rst_wdata",   bus.o_rf_wdata, 64'hABCD);
        chk("post_rst_commit",  bus.o_commit,   1);
        chk("post_rst_instret", bus.o_instret,  exp_instret);
        @(negedge i_clk);
        idle_in();
        @(posedge i_clk);
        #1;
        chk("post_rst_nodup_commit",  bus.o_commit,  0);
        chk("post_rst_nodup_instret", bus.o_instret, exp_instret);

        // Retire counter wraps modulo 2^64
        @(negedge i_clk);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap_preload", bus.o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        set_exu(5'd1, 1'b1, 64'h42);
        @(posedge i_clk);
        #1;
        chk("wrap_instret", bus.o_instret, 0);
        chk("wrap_commit",  bus.o_commit,  1);
        @(negedge i_clk);
        idle_in();
        @(posedge i_clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
